uart_rx: RTL and testbench
==========================

# uart_rx

8N1 UART receiver, the receive-side counterpart of `uart_tx`, used by the protocol analyzer's host link to accept command bytes from the PC. It synchronizes the asynchronous `rx` pin into `sys_clk`, detects and validates start bits, and samples each bit at its centre. It presents each received byte with a one-cycle valid pulse and flags framing errors.

## Interface
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz
- `BAUD_RATE`, 115200, line rate in baud
- `CLKS_PER_BIT` (localparam) = CLK_FREQ / BAUD_RATE, integer division (868 at defaults)
- `HALF_BIT` (localparam) = CLKS_PER_BIT / 2 (434 at defaults)

- `sys_clk`  input  1  system clock; all logic on its rising edge
- `sys_rst`  input  1  synchronous, active-high reset
- `rx`  input  1  asynchronous serial line, idles high
- `rx_data`  output  8  last correctly framed byte, held until the next good byte
- `rx_valid`  output  1  one-cycle pulse; `rx_data` is new this cycle
- `frame_err`  output  1  one-cycle pulse; stop bit sampled low
- `rx_busy`  output  1  high whenever the state is not IDLE

## Operation
- Input path: a 2-flop synchronizer drives `rx_s`. One further register `rx_d` holds the previous `rx_s` for falling-edge detection.
- States are IDLE, START, DATA, STOP and BREAK.
- IDLE: a falling edge (`rx_d`=1, `rx_s`=0) clears the bit counter and enters START.
- START: the counter runs to HALF_BIT-1.
  - At terminal count, if `rx_s`=0, clear the counter and enter DATA.
  - If `rx_s`=1, the start was a glitch; return to IDLE with no output.
- DATA: the counter runs to CLKS_PER_BIT-1. At each terminal count:
  - shift `rx_s` into the shift register MSB, shifting right, so the byte is received LSB first;
  - increment the 3-bit index.
  - After index 7 is sampled, enter STOP.
- STOP: the counter runs to CLKS_PER_BIT-1, then `rx_s` is sampled.
  - `rx_s`=1: load `rx_data` from the shift register, pulse `rx_valid`, go to IDLE.
  - `rx_s`=0: pulse `frame_err`, leave `rx_data` unchanged, go to BREAK.
- Leaving STOP at mid-stop-bit gives half a bit of margin to catch a back-to-back start edge.
- BREAK: stay until `rx_s`=1, then go to IDLE. This prevents a held-low line from re-triggering.
- `rx_valid` and `frame_err` are never both high in the same cycle.
- There is no backpressure. The consumer must take `rx_data` within one frame time; an unread byte is overwritten silently.

## Timing
- Reset values:
  - state IDLE, counters 0;
  - `rx_data`=8'h00, `rx_valid`=0, `frame_err`=0, `rx_busy`=0;
  - synchronizer flops and `rx_d` = 1, so reset does not produce a false edge.
- Reset applied mid-frame aborts the frame within one cycle with no pulse. A frame already in progress at release is ignored until the next falling edge seen from IDLE.
- Pin-to-detect latency: 2–3 cycles, from synchronizer plus edge detect.
- Sampling schedule, with the counter starting the cycle after the edge is detected:
  - start bit checked HALF_BIT cycles after detection;
  - data bit k sampled at HALF_BIT + (k+1)·CLKS_PER_BIT;
  - stop bit sampled at HALF_BIT + 9·CLKS_PER_BIT (8246 at defaults).
- `rx_valid` or `frame_err` is registered and is high in the cycle after the stop sample: detection + 8247 cycles at defaults.
- Counter width is $clog2(CLKS_PER_BIT). The counter wraps to 0 at each terminal count and never overflows.
- Baud tolerance is at least ±3 %, resulting from centre sampling.

## Structure
- Single module with no sub-module. The synchronizer is inline, two flops.
- A shared package `uart_pkg` holds:
  - the state encoding (IDLE=0, START=1, DATA=2, STOP=3, BREAK=4; 3 bits);
  - a function computing CLKS_PER_BIT from CLK_FREQ and BAUD_RATE, so `uart_tx` and `uart_rx` agree.

## Test plan
- Loopback with `uart_tx` at defaults: send 8'h61, 8'h41, 8'h5A back-to-back. Required: three `rx_valid` pulses with `rx_data` = 61, 41, 5A in order, and `frame_err` never high.
- Glitch: drive `rx` low for 200 ns (20 cycles), then high. Required: no `rx_valid`/`frame_err`, and `rx_busy` back low by detection + HALF_BIT + 1 cycles.
- Framing error: send 8'hA5 with the stop bit forced low, then release the line high after 2 bit times, then send 8'h3C. Required: one `frame_err` pulse, `rx_data` not 8'hA5, then `rx_valid` with 8'h3C.
- Break: hold `rx` low for 20 bit times. Required: exactly one `frame_err`, state BREAK until high, then a normally framed 8'hFF is received.
- Reset mid-frame: assert `sys_rst` for 1 cycle during bit 4 of 8'h55. Required: all outputs at reset values, no pulse for that frame, and the next 8'hC3 is received correctly.
- Baud skew: transmitter at BAUD_RATE·1.03 and ·0.97, sending 8'h00, 8'hFF, 8'h55. Required: all received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: FSM state encoding and bit-period helper
//   Used by uart_rx and uart_tx so both sides derive the same bit period.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

  // Integer division; any remainder is absorbed by centre sampling.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with centre sampling and framing-error detect
//   sys_clk   in   system clock, rising edge
//   sys_rst   in   synchronous active-high reset
//   rx        in   asynchronous serial line, idles high
//   rx_data   out  [7:0] last correctly framed byte, held until the next good byte
//   rx_valid  out  one-cycle pulse, rx_data is new
//   frame_err out  one-cycle pulse, stop bit sampled low
//   rx_busy   out  high whenever the receiver is not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e      state_q;
  logic [1:0]       sync_q;      // [0] first flop, [1] synchronized line
  logic             rx_d_q;      // previous synchronized sample, for edge detect
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q;
  logic             frame_err_q;
  logic             rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      // Line-side flops reset high so release never looks like a start edge.
      sync_q      <= 2'b11;
      rx_d_q      <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rx};
      rx_d_q      <= rx_s;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (rx_d_q && !rx_s) begin
            cnt_q   <= '0;
            state_q <= ST_START;
          end
        end

        ST_START: begin
          if (cnt_q == HALF_TC) begin
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            // A line back high at mid-start-bit was only a glitch.
            state_q   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (cnt_q == BIT_TC) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s, shift_q[7:1]};  // LSB arrives first
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (cnt_q == BIT_TC) begin
            cnt_q <= '0;
            // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start.
            if (rx_s) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
              state_q    <= ST_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_BREAK: begin
          // Wait for the line to recover so a held-low line cannot re-trigger.
          if (rx_s) begin
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with directed serial frames
module tb_uart_rx;

  localparam int unsigned CLK_FREQ  = 100_000_000;
  localparam int unsigned BAUD_RATE = 1_562_500;   // 64 clocks per bit
  localparam int          PER       = 64;
  localparam int          HALF      = 32;
  localparam int          PER_FAST  = 62;          // about +3 % baud
  localparam int          PER_SLOW  = 66;          // about -3 % baud

  logic       sys_clk;
  logic       sys_rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_good(input logic [7:0] d);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  // A framing error must leave rx_data at the last good byte.
  task automatic push_err(input logic [7:0] held);
    exp_t e;
    e.is_err = 1'b1;
    e.data   = held;
    exp_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int per, input logic stop_v);
    rx = 1'b0;
    wait_cycles(per);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cycles(per);
    end
    rx = stop_v;
    wait_cycles(per);
    rx = 1'b1;
  endtask

  // Monitor: every output pulse pops one expectation.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (rx_valid && frame_err) begin
        check("both_pulses", {rx_valid, frame_err}, 32'h0);
      end
      if (rx_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {frame_err, rx_data}, 32'hFFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_kind", frame_err, e.is_err);
          check("sb_data", rx_data, e.data);
        end
      end
    end
  end

  logic [7:0] sweep_bytes [3];

  initial begin
    rx      = 1'b1;
    sys_rst = 1'b1;
    wait_cycles(4);
    sys_rst = 1'b0;
    wait_cycles(1);

    check("rst_rx_data",   rx_data,   8'h00);
    check("rst_rx_valid",  rx_valid,  1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_rx_busy",   rx_busy,   1'b0);
    wait_cycles(8);

    // Back-to-back frames, one stop bit each.
    push_good(8'h61); send_frame(8'h61, PER, 1'b1);
    push_good(8'h41); send_frame(8'h41, PER, 1'b1);
    push_good(8'h5A); send_frame(8'h5A, PER, 1'b1);
    wait_cycles(2 * PER);

    // Short low glitch: start rejected at mid-start-bit.
    rx = 1'b0;
    wait_cycles(8);
    rx = 1'b1;
    wait_cycles(2);
    check("glitch_busy_high", rx_busy, 1'b1);
    wait_cycles(HALF + 5 - 10);
    check("glitch_busy_low", rx_busy, 1'b0);
    wait_cycles(2 * PER);

    // Stop bit low, line held low for 2 bit times, then a good byte.
    push_err(8'h5A);
    send_frame(8'hA5, PER, 1'b0);
    rx = 1'b0;
    wait_cycles(PER);
    rx = 1'b1;
    wait_cycles(2 * PER);
    check("ferr_data_held", rx_data, 8'h5A);
    push_good(8'h3C); send_frame(8'h3C, PER, 1'b1);
    wait_cycles(2 * PER);

    // Break: one error only, receiver parked until the line recovers.
    push_err(8'h3C);
    rx = 1'b0;
    wait_cycles(20 * PER);
    check("break_busy", rx_busy, 1'b1);
    rx = 1'b1;
    wait_cycles(4);
    check("break_released", rx_busy, 1'b0);
    push_good(8'hFF); send_frame(8'hFF, PER, 1'b1);
    wait_cycles(2 * PER);

    // Reset during bit 4 of 8'h55; the sender abandons the frame too.
    rx = 1'b0;
    wait_cycles(PER);
    for (int i = 0; i < 4; i++) begin
      rx = 8'h55 >> i;
      wait_cycles(PER);
    end
    rx = 1'b1;  // bit 4 of 8'h55
    wait_cycles(PER / 2);
    sys_rst = 1'b1;
    wait_cycles(1);
    sys_rst = 1'b0;
    check("midrst_rx_data",   rx_data,   8'h00);
    check("midrst_rx_valid",  rx_valid,  1'b0);
    check("midrst_frame_err", frame_err, 1'b0);
    check("midrst_rx_busy",   rx_busy,   1'b0);
    wait_cycles(12 * PER);
    push_good(8'hC3); send_frame(8'hC3, PER, 1'b1);
    wait_cycles(2 * PER);

    // Transmitter running ~3 % fast, then ~3 % slow.
    sweep_bytes[0] = 8'h00;
    sweep_bytes[1] = 8'hFF;
    sweep_bytes[2] = 8'h55;
    for (int i = 0; i < 3; i++) begin
      push_good(sweep_bytes[i]); send_frame(sweep_bytes[i], PER_FAST, 1'b1);
    end
    wait_cycles(2 * PER);
    for (int i = 0; i < 3; i++) begin
      push_good(sweep_bytes[i]); send_frame(sweep_bytes[i], PER_SLOW, 1'b1);
    end
    wait_cycles(3 * PER);

    check("sb_drained", exp_q.size(), 32'd0);
    check("final_rx_data", rx_data, 8'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
